// File: rtl/sequencer.sv
// -----------------------------------------------------------------------------
// sequencer
//   Fetch/execute sequencer for the 16-bit CPU core. Fetches a big-endian
//   16-bit instruction over the 8-bit memory port, plus an optional trailing
//   data byte. It holds the instruction, data and program counter registers
//   that feed the decoder, and applies branch and conditional-skip control flow.
//
// Parameters
//   RESET_PC        PC value loaded on reset
//
// Ports
//   clk             core clock, rising edge
//   rst_n           asynchronous active-low reset
//   run             allow a new instruction (sampled in IDLE / at boundary)
//   mem_req         memory read request
//   mem_addr[15:0]  byte address of the read (always the current pc)
//   mem_rdata[7:0]  read data, valid while mem_ack is high
//   mem_ack         read complete
//   inst[15:0]      instruction register to the decoder
//   data[7:0]       data-byte register to the decoder
//   dec_en          decoder enable (DECODE and EXEC)
//   dec_source_data decoder: instruction has a data byte
//   dec_branch      decoder: branch instruction
//   dec_if          decoder: conditional instruction
//   dec_rhs[15:0]   decoder: sign-extended branch offset
//   cond_true       datapath: selected condition holds
//   exec_en         datapath execute strobe
//   exec_stall      datapath busy, hold EXEC
//   pc[15:0]        program counter (next byte to fetch)
//   halted          high while idle
// -----------------------------------------------------------------------------
module sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] inst,
   output logic [7:0]  data,
   output logic        dec_en,
   input  logic        dec_source_data,
   input  logic        dec_branch,
   input  logic        dec_if,
   input  logic [15:0] dec_rhs,
   input  logic        cond_true,
   output logic        exec_en,
   input  logic        exec_stall,
   output logic [15:0] pc,
   output logic        halted
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_HI,
      ST_FETCH_LO,
      ST_DECODE,
      ST_FETCH_DATA,
      ST_EXEC
   } state_t;

   state_t      state, state_nxt, boundary_nxt;
   logic        skip, skip_nxt;
   logic [15:0] pc_nxt;
   logic [15:0] inst_nxt;
   logic [7:0]  data_nxt;
   logic signed [15:0] rhs_s;

   assign rhs_s = dec_rhs;

   // The fetch address is always the pc; it cannot move while a read waits
   // because pc only advances on mem_ack.
   assign mem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
         inst  <= 16'h0000;
         data  <= 8'h00;
         skip  <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         inst  <= inst_nxt;
         data  <= data_nxt;
         skip  <= skip_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      inst_nxt  = inst;
      data_nxt  = data;
      skip_nxt  = skip;
      mem_req   = 1'b0;
      dec_en    = 1'b0;
      exec_en   = 1'b0;
      halted    = 1'b0;
      // Instruction boundary: a combinational decision, so back-to-back
      // instructions run without a bubble.
      boundary_nxt = run ? ST_FETCH_HI : ST_IDLE;

      case (state)
         ST_IDLE: begin
            halted = 1'b1;
            if (run) state_nxt = ST_FETCH_HI;
         end
         ST_FETCH_HI: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               inst_nxt[15:8] = mem_rdata;
               pc_nxt         = pc + 16'd1;
               state_nxt      = ST_FETCH_LO;
            end
         end
         ST_FETCH_LO: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               inst_nxt[7:0] = mem_rdata;
               pc_nxt        = pc + 16'd1;
               state_nxt     = ST_DECODE;
            end
         end
         ST_DECODE: begin
            dec_en = 1'b1;
            // A skipped instruction is still sized, so its data byte is fetched.
            if (dec_source_data) begin
               state_nxt = ST_FETCH_DATA;
            end else if (skip) begin
               skip_nxt  = 1'b0;
               state_nxt = boundary_nxt;
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         ST_FETCH_DATA: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               data_nxt = mem_rdata;
               pc_nxt   = pc + 16'd1;
               if (skip) begin
                  skip_nxt  = 1'b0;
                  state_nxt = boundary_nxt;
               end else begin
                  state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            dec_en  = 1'b1;
            exec_en = 1'b1;
            if (!exec_stall) begin
               // pc already points past this instruction; offset wraps mod 2^16.
               if (dec_branch) pc_nxt = $unsigned($signed(pc) + rhs_s);
               if (dec_if && !cond_true) skip_nxt = 1'b1;
               state_nxt = boundary_nxt;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sequencer
//   Directed bench for sequencer. A byte-array memory answers reads, a tiny
//   decoder derives control from inst (bit15 data byte, bit14 branch, bit13 if,
//   rhs = sign-extended inst[7:0]). Expected executed {inst,data} pairs are
//   queued when a program is loaded and popped when exec completes.
// -----------------------------------------------------------------------------
module tb_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic [15:0] inst;
   logic [7:0]  data;
   logic        dec_en;
   logic        dec_source_data;
   logic        dec_branch;
   logic        dec_if;
   logic [15:0] dec_rhs;
   logic        cond_true;
   logic        exec_en;
   logic        exec_stall;
   logic [15:0] pc;
   logic        halted;

   logic [7:0]  mem [0:65535];
   logic [23:0] exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          exec_pulses = 0;
   logic        prev_exec = 1'b0;

   sequencer #(.RESET_PC(16'h0000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .run             (run),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_rdata       (mem_rdata),
      .mem_ack         (mem_ack),
      .inst            (inst),
      .data            (data),
      .dec_en          (dec_en),
      .dec_source_data (dec_source_data),
      .dec_branch      (dec_branch),
      .dec_if          (dec_if),
      .dec_rhs         (dec_rhs),
      .cond_true       (cond_true),
      .exec_en         (exec_en),
      .exec_stall      (exec_stall),
      .pc              (pc),
      .halted          (halted)
   );

   assign mem_rdata       = mem[mem_addr];
   assign dec_source_data = inst[15];
   assign dec_branch      = inst[14];
   assign dec_if          = inst[13];
   assign dec_rhs         = {{8{inst[7]}}, inst[7:0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      run        = 1'b0;
      mem_ack    = 1'b1;
      exec_stall = 1'b0;
      cond_true  = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Scoreboard consumer: one entry per completed EXEC.
   always @(negedge clk) begin
      logic [23:0] e;
      if (rst_n && exec_en && !exec_stall) begin
         chk("exec_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("exec_inst", {16'h0, inst}, {16'h0, e[23:8]});
            chk("exec_data", {24'h0, data}, {24'h0, e[7:0]});
         end
      end
      if (exec_en && !prev_exec) exec_pulses++;
      prev_exec = exec_en;
   end

   initial begin
      int p0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      // ---- Reset state ----
      do_reset();
      chk("rst_halted",  {31'h0, halted},  32'd1);
      chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
      chk("rst_addr",    {16'h0, mem_addr}, 32'h0);
      chk("rst_pc",      {16'h0, pc},     32'h0);
      chk("rst_inst",    {16'h0, inst},   32'h0);
      chk("rst_data",    {24'h0, data},   32'h0);
      chk("rst_dec_en",  {31'h0, dec_en}, 32'd0);
      chk("rst_exec_en", {31'h0, exec_en}, 32'd0);

      // ---- Basic 2-byte instruction, back-to-back ----
      exp_q.push_back(24'h0000_00);
      exp_q.push_back(24'h0000_00);
      run = 1'b1;
      tick();
      chk("a_c1_req",  {31'h0, mem_req}, 32'd1);
      chk("a_c1_addr", {16'h0, mem_addr}, 32'h0);
      tick();
      chk("a_c2_addr", {16'h0, mem_addr}, 32'h1);
      tick();
      chk("a_c3_dec_en", {31'h0, dec_en},  32'd1);
      chk("a_c3_exec",   {31'h0, exec_en}, 32'd0);
      chk("a_c3_req",    {31'h0, mem_req}, 32'd0);
      tick();
      chk("a_c4_exec", {31'h0, exec_en}, 32'd1);
      tick();
      chk("a_c5_req",  {31'h0, mem_req}, 32'd1);
      chk("a_c5_addr", {16'h0, mem_addr}, 32'h2);
      run = 1'b0;
      repeat (4) tick();
      chk("a_halted", {31'h0, halted}, 32'd1);
      chk("a_pc",     {16'h0, pc},     32'h4);

      // ---- Data-byte instruction ----
      mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h5A;
      do_reset();
      exp_q.push_back(24'h8200_5A);
      run = 1'b1;
      repeat (4) tick();
      chk("b_c4_req",  {31'h0, mem_req}, 32'd1);
      chk("b_c4_addr", {16'h0, mem_addr}, 32'h2);
      chk("b_c4_inst", {16'h0, inst},    32'h8200);
      chk("b_c4_exec", {31'h0, exec_en}, 32'd0);
      tick();
      chk("b_c5_exec", {31'h0, exec_en}, 32'd1);
      chk("b_c5_data", {24'h0, data},    32'h5A);
      run = 1'b0;
      tick();
      chk("b_halted", {31'h0, halted}, 32'd1);
      chk("b_pc",     {16'h0, pc},     32'h3);

      // ---- Branches, including wrap past 16'hFFFF ----
      mem[16'h0000] = 8'h40; mem[16'h0001] = 8'h0E;  // -> 0x0010
      mem[16'h0010] = 8'h40; mem[16'h0011] = 8'hF0;  // 0x12 + FFF0 -> 0x0002
      mem[16'h0002] = 8'h40; mem[16'h0003] = 8'hF8;  // 0x04 + FFF8 -> 0xFFFC
      mem[16'hFFFC] = 8'h40; mem[16'hFFFD] = 8'h04;  // 0xFFFE + 4 -> 0x0002
      do_reset();
      exp_q.push_back(24'h400E_00);
      exp_q.push_back(24'h40F0_00);
      exp_q.push_back(24'h40F8_00);
      exp_q.push_back(24'h4004_00);
      run = 1'b1;
      repeat (5) tick();
      chk("c_br1_addr", {16'h0, mem_addr}, 32'h0010);
      repeat (4) tick();
      chk("c_br2_addr", {16'h0, mem_addr}, 32'h0002);
      repeat (4) tick();
      chk("c_br3_addr", {16'h0, mem_addr}, 32'hFFFC);
      tick();
      chk("c_fl_addr", {16'h0, mem_addr}, 32'hFFFD);
      repeat (2) tick();
      chk("c_exec_pc", {16'h0, pc}, 32'hFFFE);
      run = 1'b0;
      tick();
      chk("c_halted", {31'h0, halted}, 32'd1);
      chk("c_wrap_pc", {16'h0, pc},   32'h0002);

      // ---- Conditional skip over a data-byte branch+if instruction ----
      mem[0] = 8'h20; mem[1] = 8'h00;                 // if, condition false
      mem[2] = 8'hE0; mem[3] = 8'h05; mem[4] = 8'h77; // skipped
      mem[5] = 8'h00; mem[6] = 8'h00;                 // executes
      do_reset();
      cond_true = 1'b0;
      exp_q.push_back(24'h2000_00);
      exp_q.push_back(24'h0000_77);
      run = 1'b1;
      repeat (4) tick();
      chk("d_if_exec", {31'h0, exec_en}, 32'd1);
      for (int c = 5; c <= 8; c++) begin
         tick();
         chk($sformatf("d_skip_c%0d_exec", c), {31'h0, exec_en}, 32'd0);
      end
      chk("d_skip_data_addr", {16'h0, mem_addr}, 32'h4);
      tick();
      chk("d_next_addr", {16'h0, mem_addr}, 32'h5);
      chk("d_next_req",  {31'h0, mem_req},  32'd1);
      repeat (3) tick();
      chk("d_next_exec", {31'h0, exec_en}, 32'd1);
      run = 1'b0;
      tick();
      chk("d_pc", {16'h0, pc}, 32'h7);

      // ---- Memory wait states and exec stall ----
      mem[0] = 8'h00; mem[1] = 8'h00;
      do_reset();
      exp_q.push_back(24'h0000_00);
      p0 = exec_pulses;
      run = 1'b1;
      tick();                       // cycle 1 FETCH_HI
      tick();                       // cycle 2 FETCH_LO
      mem_ack = 1'b0;
      chk("e_c2_addr", {16'h0, mem_addr}, 32'h1);
      tick();
      chk("e_c3_addr", {16'h0, mem_addr}, 32'h1);
      chk("e_c3_req",  {31'h0, mem_req},  32'd1);
      tick();
      chk("e_c4_addr", {16'h0, mem_addr}, 32'h1);
      tick();                       // cycle 5, ack returns
      mem_ack = 1'b1;
      chk("e_c5_addr", {16'h0, mem_addr}, 32'h1);
      tick();                       // cycle 6 DECODE
      chk("e_c6_dec", {31'h0, dec_en}, 32'd1);
      chk("e_c6_exec", {31'h0, exec_en}, 32'd0);
      tick();                       // cycle 7 EXEC
      exec_stall = 1'b1;
      chk("e_c7_exec", {31'h0, exec_en}, 32'd1);
      tick();
      chk("e_c8_exec", {31'h0, exec_en}, 32'd1);
      tick();                       // cycle 9 last EXEC cycle
      exec_stall = 1'b0;
      chk("e_c9_exec", {31'h0, exec_en}, 32'd1);
      run = 1'b0;
      tick();
      chk("e_c10_exec", {31'h0, exec_en}, 32'd0);
      chk("e_halted",   {31'h0, halted},  32'd1);
      chk("e_pulses",   32'(exec_pulses - p0), 32'd1);

      // ---- Async reset during FETCH_DATA ----
      mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h5A;
      do_reset();
      run = 1'b1;
      repeat (4) tick();
      mem_ack = 1'b0;
      chk("f_fd_req", {31'h0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("f_rst_req",    {31'h0, mem_req}, 32'd0);
      chk("f_rst_halted", {31'h0, halted},  32'd1);
      chk("f_rst_pc",     {16'h0, pc},      32'h0);
      chk("f_rst_inst",   {16'h0, inst},    32'h0);
      tick();
      rst_n   = 1'b1;
      mem_ack = 1'b1;
      exp_q.push_back(24'h8200_5A);
      tick();
      chk("f_restart_req",  {31'h0, mem_req},  32'd1);
      chk("f_restart_addr", {16'h0, mem_addr}, 32'h0);
      repeat (4) tick();
      chk("f_exec", {31'h0, exec_en}, 32'd1);
      run = 1'b0;
      tick();
      chk("f_pc", {16'h0, pc}, 32'h3);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
